conv_encoder_puncturer: RTL and testbench
=========================================

// Module: conv_encoder_puncturer
// PURPOSE
// - Transmit-side 802.11a convolutional encoder: K=7, g0=133(oct) -> A, g1=171(oct) -> B, followed by puncturing to 1/2, 2/3 or 3/4.
// - Sits between the scrambler and the interleaver. Converts a bit-serial valid/ready stream into a bit-serial coded stream.
// - Its output is the stream the receive-side Viterbi decoder consumes.
// PARAMETERS
// - CNT_W   10   width of OutCount, the coded-bit counter for the current frame (wraps)
// PORTS
// - Clock     in   1   rising-edge clock
// - Reset     in   1   asynchronous, active-high reset
// - Start     in   1   1-cycle frame start: clears state and latches Rate
// - Rate      in   2   00=1/2, 01=2/3, 10=3/4, 11=reserved (treated as 1/2); sampled only when Start=1
// - InValid   in   1   InBit is valid
// - InBit     in   1   scrambled data bit
// - InReady   out  1   encoder accepts InBit this cycle
// - OutValid  out  1   OutBit is valid
// - OutBit    out  1   coded bit
// - OutReady  in   1   downstream accepts OutBit this cycle
// - OutCount  out  CNT_W  coded bits emitted since the last Start
// BEHAVIOUR
// - Reset values: sr=0, phase=0, pend_cnt=0, rate_q=1/2, InReady=0, OutValid=0, OutBit=0, OutCount=0.
// - Core: sr[5:0], where sr[0]=b[n-1] and sr[5]=b[n-6].
//   - A = b ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]
//   - B = b ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5]
//   - On accept: sr <= {sr[4:0], b}.
// - Accept happens when InValid && InReady.
//   - Computed bits load into a 2-entry pending buffer, ordered A then B, masked by the puncture pattern.
//   - pend_cnt <= number of kept bits (1 or 2).
// - Puncture phase counter:
//   - Rate 1/2: phase always 0; keep A and B.
//   - Rate 2/3: phase 0,1; ph0 keep A,B; ph1 keep A only.
//   - Rate 3/4: phase 0,1,2; ph0 keep A,B; ph1 keep A only; ph2 keep B only.
//   - Phase advances on every accept and wraps to 0 after the last phase.
// - Output side:
//   - OutValid = (pend_cnt != 0); OutBit = head of the pending buffer. Both driven from registers.
//   - On OutValid && OutReady: pop the head and increment OutCount (modulo 2^CNT_W).
// - InReady = !Start && (pend_cnt==0 || (pend_cnt==1 && OutReady)).
//   - A pop and a load may coincide; the new bits then follow immediately with no bubble.
// - Latency and throughput:
//   - The first kept bit of an input accepted in cycle t is visible on OutBit in cycle t+1.
//   - With OutReady held at 1, output is 1 bit per cycle; input runs at 1/2, 2/3 or 3/4 bit per cycle.
// - Stall: while OutValid && !OutReady, OutBit and OutValid hold stable.
// - Start, any cycle:
//   - Next cycle: sr=0, phase=0, pend_cnt=0 (pending bits are discarded), OutCount=0, rate_q=Rate.
//   - InReady=0 during the Start cycle, so no accept coincides with Start.
// - Rate changes without Start are ignored. Tail and pad bits are the supplier's job; the block has no flush state.
// - Reset mid-frame: immediate return to reset values; the partial frame is lost.
// STRUCTURE
// - Shared package:
//   - rate encodings RATE_1_2=2'b00, RATE_2_3=2'b01, RATE_3_4=2'b10
//   - G0=7'o133, G1=7'o171
//   - puncture keep-mask table indexed by {rate, phase}
// - Sub-module conv_k7_core holds sr and computes {A,B}.
//   - Ports: Clock, Reset, Clear, Shift, InBit, A, B.
//   - Shared with a future reference encoder used by the decoder bench.
// - Top level holds the phase counter, the pending buffer, the handshake and OutCount.
// TESTING
// - Rate 1/2 impulse: Start, then bits 1,0,0,0,0,0,0 with OutReady=1 -> OutBit 11 01 11 11 00 10 11; OutCount=14.
// - Rate 2/3, same impulse -> 1,1,0,1,1,1,0,0,1,1,1 (11 bits); InReady low 1 of every 3 cycles.
// - Rate 3/4, same impulse -> 1,1,0,1,1,1,0,0,1,1 (10 bits).
// - Backpressure: rate 1/2, OutReady toggles 1,0,1,0 -> same bit sequence as the impulse test; OutBit stable during stalls; no input accepted while pend_cnt==2.
// - Start mid-frame with pend_cnt=1, Rate=10 -> next cycle OutValid=0, OutCount=0; the following impulse yields the 3/4 sequence.
// - Reset asserted while OutValid=1 -> OutValid, InReady and OutCount go to 0 asynchronously; Rate=11 after Start behaves as 1/2.

Source files
------------

// File: rtl/conv_encoder_puncturer_pkg.sv
// Shared definitions for the K=7 802.11a convolutional encoder and its puncturer:
// rate codes, generator polynomials and the puncture keep-mask table.
package conv_encoder_puncturer_pkg;

  localparam int unsigned CNT_W_DEF = 10;
  localparam int unsigned SR_W      = 6;
  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned PEND_W    = 2;

  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  // Two bits per {rate, phase} entry: [1] keeps A, [0] keeps B; unused slots keep both.
  localparam logic [31:0] PUNCT_KEEP = 32'b11111111_11011011_11111011_11111111;

  function automatic logic [1:0] keep_mask(input rate_e rate, input logic [PHASE_W-1:0] phase);
    logic [3:0] idx;
    idx = {rate, phase};
    return PUNCT_KEEP[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [PHASE_W-1:0] last_phase(input rate_e rate);
    case (rate)
      RATE_2_3: return PHASE_W'(1);
      RATE_3_4: return PHASE_W'(2);
      default:  return PHASE_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/conv_encoder_puncturer_if.sv
// Bit-serial input and coded-output handshake bundle of the encoder/puncturer.
interface conv_encoder_puncturer_if #(
  parameter int unsigned CNT_W = 10
);
  logic             start;
  logic [1:0]       rate;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready_c;
  logic             out_valid;
  logic             out_bit;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;

  modport master (
    output start, rate, in_valid, in_bit, out_ready,
    input  in_ready_c, out_valid, out_bit, out_count
  );

  modport slave (
    input  start, rate, in_valid, in_bit, out_ready,
    output in_ready_c, out_valid, out_bit, out_count
  );
endinterface

// File: rtl/conv_k7_core.sv
// K=7 shift register with combinational A (g0=133) and B (g1=171) outputs for the current bit.
module conv_k7_core
  import conv_encoder_puncturer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic shift_i,
  input  logic in_bit_i,
  output logic a_c_o,
  output logic b_c_o
);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [6:0]      win_c;

  // Window MSB is the incoming bit, LSB the oldest stored bit, matching octal tap order.
  always_comb begin
    win_c = {in_bit_i, sr_q[0], sr_q[1], sr_q[2], sr_q[3], sr_q[4], sr_q[5]};
    a_c_o = ^(win_c & G0);
    b_c_o = ^(win_c & G1);
    sr_d  = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (shift_i) begin
      sr_d = {sr_q[SR_W-2:0], in_bit_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/conv_encoder_puncturer.sv
// Top: puncture phase counter, 2-entry pending buffer, handshakes and coded-bit counter.
module conv_encoder_puncturer
  import conv_encoder_puncturer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  conv_encoder_puncturer_if.slave  bus
);

  rate_e              rate_q, rate_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         pend_q, pend_d;
  logic [PEND_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q, out_bit_d;
  logic               pop_c, acc_c, a_c, b_c;
  logic [1:0]         mask_c;

  // A single pending bit may be replaced in the same cycle it is popped.
  assign bus.in_ready_c = !rst_i && !bus.start &&
                          ((pend_cnt_q == PEND_W'(0)) ||
                           ((pend_cnt_q == PEND_W'(1)) && bus.out_ready));
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_count  = out_count_q;

  assign pop_c  = out_valid_q && bus.out_ready;
  assign acc_c  = bus.in_valid && bus.in_ready_c;
  assign mask_c = keep_mask(rate_q, phase_q);

  conv_k7_core u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (bus.start),
    .shift_i  (acc_c),
    .in_bit_i (bus.in_bit),
    .a_c_o    (a_c),
    .b_c_o    (b_c)
  );

  always_comb begin
    rate_d      = rate_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    pend_cnt_d  = pend_cnt_q;
    out_count_d = out_count_q;
    if (pop_c) begin
      pend_d      = {1'b0, pend_q[1]};
      pend_cnt_d  = pend_cnt_q - PEND_W'(1);
      out_count_d = out_count_q + CNT_W'(1);
    end
    // Accept only happens with the buffer empty after any pop, so a load overwrites it.
    if (acc_c) begin
      case (mask_c)
        2'b10: begin pend_d = {1'b0, a_c}; pend_cnt_d = PEND_W'(1); end
        2'b01: begin pend_d = {1'b0, b_c}; pend_cnt_d = PEND_W'(1); end
        default: begin pend_d = {b_c, a_c}; pend_cnt_d = PEND_W'(2); end
      endcase
      phase_d = (phase_q == last_phase(rate_q)) ? '0 : phase_q + PHASE_W'(1);
    end
    if (bus.start) begin
      rate_d      = rate_e'(bus.rate);
      phase_d     = '0;
      pend_d      = '0;
      pend_cnt_d  = '0;
      out_count_d = '0;
    end
    out_valid_d = (pend_cnt_d != PEND_W'(0));
    out_bit_d   = pend_d[0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rate_q      <= RATE_1_2;
      phase_q     <= '0;
      pend_q      <= '0;
      pend_cnt_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_puncturer.sv
// Directed bench for conv_encoder_puncturer: impulse responses at each rate,
// backpressure, mid-frame Start and mid-frame reset.
module tb_conv_encoder_puncturer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  conv_encoder_puncturer_if #(.CNT_W(10)) bus();

  conv_encoder_puncturer #(.CNT_W(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds the 7-bit impulse 1,0,0,0,0,0,0 and checks the coded stream (exp is MSB-first).
  task automatic run_stream(input string tag, input logic do_start, input logic [1:0] rate,
                            input int n_exp, input logic [15:0] exp, input int exp_lows,
                            input logic bp);
    int   k, sent, lows, first_acc, first_val;
    logic stalled, held_b;
    k = 0; sent = 0; lows = 0; first_acc = -1; first_val = -1;
    stalled = 1'b0; held_b = 1'b0;
    if (do_start) begin
      bus.start = 1'b1; bus.rate = rate; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      chk({tag, "_start_rdy"}, 32'(bus.in_ready_c), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_start_ov"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_start_cnt"}, 32'(bus.out_count), 32'd0);
    end
    for (int cyc = 0; cyc < 200 && (k < n_exp || sent < 7); cyc++) begin
      bus.in_valid  = (sent < 7);
      bus.in_bit    = (sent == 0);
      bus.out_ready = bp ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (stalled) begin
        chk({tag, "_hold_ov"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_bit"}, 32'(bus.out_bit), 32'(held_b));
      end
      if (bus.out_valid && first_val < 0) first_val = cyc;
      if (bus.out_valid && !bus.out_ready) begin
        chk({tag, "_stall_rdy"}, 32'(bus.in_ready_c), 32'd0);
        stalled = 1'b1;
        held_b  = bus.out_bit;
      end else begin
        stalled = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (k < n_exp) chk($sformatf("%s_bit%0d", tag, k), 32'(bus.out_bit), 32'(exp[n_exp-1-k]));
        else           chk({tag, "_extra"}, 32'(k + 1), 32'(n_exp));
        k++;
      end
      if (bus.in_valid && !bus.in_ready_c) lows++;
      if (bus.in_valid && bus.in_ready_c) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk({tag, "_nbits"}, 32'(k), 32'(n_exp));
    chk({tag, "_latency"}, 32'(first_val - first_acc), 32'd1);
    if (exp_lows >= 0) chk({tag, "_rdy_lows"}, 32'(lows), 32'(exp_lows));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(n_exp));
    chk({tag, "_idle_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.rate = 2'b00; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_bit", 32'(bus.out_bit), 32'd0);
    chk("rst_cnt", 32'(bus.out_count), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready_c), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_stream("r12", 1'b1, 2'b00, 14, 16'b00_11011111001011, 6, 1'b0);
    run_stream("r23", 1'b1, 2'b01, 11, 16'b00000_11011100111, 3, 1'b0);
    run_stream("r34", 1'b1, 2'b10, 10, 16'b000000_1101110011, 2, 1'b0);
    run_stream("bp", 1'b1, 2'b00, 14, 16'b00_11011111001011, -1, 1'b1);

    // Start while one pending bit remains, switching to 3/4.
    bus.start = 1'b1; bus.rate = 2'b00; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    #1;
    chk("mid_acc_rdy", 32'(bus.in_ready_c), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_ov", 32'(bus.out_valid), 32'd1);
    chk("mid_cnt", 32'(bus.out_count), 32'd1);
    bus.out_ready = 1'b0; bus.start = 1'b1; bus.rate = 2'b10;
    #1;
    chk("mid_start_rdy", 32'(bus.in_ready_c), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mid_after_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_after_cnt", 32'(bus.out_count), 32'd0);
    run_stream("mid34", 1'b0, 2'b10, 10, 16'b000000_1101110011, 2, 1'b0);

    // Reset in the middle of a frame with a bit still pending.
    bus.start = 1'b1; bus.rate = 2'b00; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    #1;
    chk("prerst_ov", 32'(bus.out_valid), 32'd1);
    chk("prerst_cnt", 32'(bus.out_count), 32'd1);
    chk("prerst_rdy", 32'(bus.in_ready_c), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ov", 32'(bus.out_valid), 32'd0);
    chk("arst_rdy", 32'(bus.in_ready_c), 32'd0);
    chk("arst_cnt", 32'(bus.out_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_stream("rsvd", 1'b1, 2'b11, 14, 16'b00_11011111001011, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
